// File: rtl/uart_pkg.sv
// Shared UART receive definitions: data width, default bit period, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a configurable reset value.
// Latency: 2 clk cycles from input change to output change.
// Backpressure: none; the output follows the input continuously.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second gives it a cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: deserialises 8N1 (optional parity) frames into bytes, flags framing/parity errors.
// Latency: strobe lands 1 cycle after the mid-stop-bit sample (2 sync + 1 + CPB/2 + 9*CPB after the line edge, no parity).
// Backpressure: none; rxd/rx_dv is a push interface and the consumer must take every strobe.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    output logic [UART_DATA_W-1:0] rxd,
    output logic                   rx_dv,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam int             TW      = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(CLKS_PER_BIT - 1);

    rx_state_e              state;
    rx_state_e              state_nxt;
    logic                   s_rx;
    logic                   s_rx_d;
    logic                   fall;
    logic                   tick;
    logic [TW-1:0]          timer;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   par_bad;
    logic                   dv_set;
    logic                   fe_set;
    logic                   pe_set;

    // Line idles high, so the synchroniser resets to 1 to avoid a fake start edge out of reset.
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (s_rx)
    );

    // Delayed copy of the synchronised line for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rx_d <= 1'b1;
        end else begin
            s_rx_d <= s_rx;
        end
    end

    assign fall = s_rx_d & ~s_rx;

    // Sample point: mid start bit in START, then one full bit period per sample after that.
    always_comb begin
        tick = 1'b0;
        case (state)
            START:              tick = (timer == HALF_M1);
            DATA, PARITY, STOP: tick = (timer == FULL_M1);
            default:            tick = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fall) state_nxt = START;
            START:  if (tick) state_nxt = s_rx ? IDLE : DATA;
            DATA:   if (tick && bit_idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
            PARITY: if (tick) state_nxt = STOP;
            STOP:   if (tick) state_nxt = s_rx ? IDLE : BREAK;
            BREAK:  if (s_rx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: at most one strobe decision per frame, taken at the stop-bit sample.
    always_comb begin
        dv_set = 1'b0;
        fe_set = 1'b0;
        pe_set = 1'b0;
        if (state == STOP && tick) begin
            dv_set = s_rx & ~par_bad;
            pe_set = s_rx & par_bad;
            fe_set = ~s_rx;
        end
    end

    // Bit timer: held at zero while waiting for a frame, wraps to zero on every sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == IDLE || state == BREAK || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Data capture, bit index and latched parity mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= 3'd0;
            shift_reg <= '0;
            par_bad   <= 1'b0;
        end else if (tick) begin
            case (state)
                START: begin
                    bit_idx <= 3'd0;
                    par_bad <= 1'b0;
                end
                DATA: begin
                    shift_reg[bit_idx] <= s_rx;
                    bit_idx            <= bit_idx + 3'd1;
                end
                PARITY: par_bad <= (s_rx != ((^shift_reg) ^ PARITY_ODD));
                default: ;
            endcase
        end
    end

    // Registered strobes; rxd only moves on a good byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd        <= '0;
            rx_dv      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_dv      <= dv_set;
            frame_err  <= fe_set;
            parity_err <= pe_set;
            if (dv_set) begin
                rxd <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line0, line1;
    logic [7:0] rxd0, rxd1;
    logic       dv0, fe0, pe0, dv1, fe1, pe1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line0),
        .rxd(rxd0), .rx_dv(dv0), .frame_err(fe0), .parity_err(pe0)
    );

    uart_rx_deser #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line1),
        .rxd(rxd1), .rx_dv(dv1), .frame_err(fe1), .parity_err(pe1)
    );

    // Strobe monitor: counts strobes and logs received bytes, sampled on the falling edge.
    int         dv_cnt0 = 0, fe_cnt0 = 0, pe_cnt0 = 0;
    int         dv_cnt1 = 0, fe_cnt1 = 0, pe_cnt1 = 0;
    int         overlap_cnt = 0;
    int         last_dv_cyc0 = 0;
    logic [7:0] log0 [0:255];
    logic [7:0] log1 [0:255];

    always @(negedge clk) begin
        if (dv0 === 1'b1) begin
            log0[dv_cnt0 % 256] = rxd0;
            last_dv_cyc0 = cyc;
            dv_cnt0++;
        end
        if (fe0 === 1'b1) fe_cnt0++;
        if (pe0 === 1'b1) pe_cnt0++;
        if (dv1 === 1'b1) begin
            log1[dv_cnt1 % 256] = rxd1;
            dv_cnt1++;
        end
        if (fe1 === 1'b1) fe_cnt1++;
        if (pe1 === 1'b1) pe_cnt1++;
        if (int'(dv0) + int'(fe0) + int'(pe0) > 1 || int'(dv1) + int'(fe1) + int'(pe1) > 1)
            overlap_cnt++;
    end

    // Frame as a bit vector in line order: start, D0..D7, [parity], stop.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit par_en,
                                               input bit par_bit, input bit stop_bit);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (par_en) begin
            b[9]  = par_bit;
            b[10] = stop_bit;
        end else begin
            b[9] = stop_bit;
        end
        return b;
    endfunction

    task automatic send_bits(input bit sel, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) line1 = bits[i];
            else     line0 = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit);
        send_bits(sel, frame_bits(d, par_en, par_bit, stop_bit), par_en ? 11 : 10);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        idle(2);
        checks++;
        if ({rxd0, dv0, fe0, pe0} !== 11'h000) begin
            errors++;
            $display("FAIL reset_dut0: got %h required 000", {rxd0, dv0, fe0, pe0});
        end
        checks++;
        if ({rxd1, dv1, fe1, pe1} !== 11'h000) begin
            errors++;
            $display("FAIL reset_dut1: got %h required 000", {rxd1, dv1, fe1, pe1});
        end
        rst_n = 1'b1;
        idle(3 * CPB);
        checks++;
        if (dv_cnt0 + fe_cnt0 + pe_cnt0 + dv_cnt1 + fe_cnt1 + pe_cnt1 !== 0) begin
            errors++;
            $display("FAIL idle_no_strobe: got %0d strobes required 0",
                     dv_cnt0 + fe_cnt0 + pe_cnt0 + dv_cnt1 + fe_cnt1 + pe_cnt1);
        end
    endtask

    task automatic test_single_a5();
        int b, t0;
        do_reset();
        b  = dv_cnt0;
        t0 = cyc;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt0 - b !== 1) begin
            errors++;
            $display("FAIL a5_count: got %0d required 1", dv_cnt0 - b);
        end
        checks++;
        if (rxd0 !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data: got %h required a5", rxd0);
        end
        // 2 sync edges, then 1 + CPB/2 + 9*CPB to the registered strobe.
        checks++;
        if (last_dv_cyc0 - t0 !== 2 + 1 + CPB / 2 + 9 * CPB) begin
            errors++;
            $display("FAIL a5_latency: got %0d required %0d", last_dv_cyc0 - t0,
                     2 + 1 + CPB / 2 + 9 * CPB);
        end
    endtask

    task automatic test_back_to_back();
        int b, fb, pb;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        do_reset();
        b = dv_cnt0; fb = fe_cnt0; pb = pe_cnt0;
        for (int i = 0; i < 3; i++) send_frame(1'b0, exp_b[i], 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt0 - b !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 3", dv_cnt0 - b);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log0[(b + i) % 256] !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, log0[(b + i) % 256], exp_b[i]);
            end
        end
        checks++;
        if ((fe_cnt0 - fb) + (pe_cnt0 - pb) !== 0) begin
            errors++;
            $display("FAIL b2b_errs: got %0d required 0", (fe_cnt0 - fb) + (pe_cnt0 - pb));
        end
    endtask

    task automatic test_glitch();
        int b, fb;
        do_reset();
        b = dv_cnt0; fb = fe_cnt0;
        line0 = 1'b0;
        idle(4);
        line0 = 1'b1;
        idle(3 * CPB);
        checks++;
        if ((dv_cnt0 - b) + (fe_cnt0 - fb) !== 0) begin
            errors++;
            $display("FAIL glitch_strobe: got %0d required 0", (dv_cnt0 - b) + (fe_cnt0 - fb));
        end
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt0 - b !== 1 || rxd0 !== 8'hC3) begin
            errors++;
            $display("FAIL glitch_recover: got count %0d byte %h required 1 c3", dv_cnt0 - b, rxd0);
        end
    endtask

    task automatic test_break();
        int b, fb;
        do_reset();
        b = dv_cnt0; fb = fe_cnt0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(40 * CPB);
        checks++;
        if (fe_cnt0 - fb !== 1 || dv_cnt0 - b !== 0) begin
            errors++;
            $display("FAIL break_fe: got fe %0d dv %0d required 1 0", fe_cnt0 - fb, dv_cnt0 - b);
        end
        checks++;
        if (rxd0 !== 8'h00) begin
            errors++;
            $display("FAIL break_rxd: got %h required 00", rxd0);
        end
        line0 = 1'b1;
        idle(2 * CPB);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt0 - b !== 1 || rxd0 !== 8'h12 || fe_cnt0 - fb !== 1) begin
            errors++;
            $display("FAIL break_next: got dv %0d byte %h fe %0d required 1 12 1",
                     dv_cnt0 - b, rxd0, fe_cnt0 - fb);
        end
    endtask

    task automatic test_parity();
        int b, pb, fb;
        do_reset();
        b = dv_cnt1; pb = pe_cnt1; fb = fe_cnt1;
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt1 - b !== 1 || rxd1 !== 8'h03 || pe_cnt1 - pb !== 0) begin
            errors++;
            $display("FAIL par_good: got dv %0d byte %h pe %0d required 1 03 0",
                     dv_cnt1 - b, rxd1, pe_cnt1 - pb);
        end
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt1 - b !== 1 || rxd1 !== 8'h03 || pe_cnt1 - pb !== 1 || fe_cnt1 - fb !== 0) begin
            errors++;
            $display("FAIL par_bad: got dv %0d byte %h pe %0d fe %0d required 1 03 1 0",
                     dv_cnt1 - b, rxd1, pe_cnt1 - pb, fe_cnt1 - fb);
        end
    endtask

    task automatic test_reset_mid();
        int b, fb;
        do_reset();
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        b = dv_cnt0; fb = fe_cnt0;
        send_bits(1'b0, frame_bits(8'h9E, 1'b0, 1'b0, 1'b1), 4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rxd0, dv0, fe0, pe0} !== 11'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got %h required 000", {rxd0, dv0, fe0, pe0});
        end
        line0 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(2 * CPB);
        checks++;
        if ((dv_cnt0 - b) + (fe_cnt0 - fb) !== 0) begin
            errors++;
            $display("FAIL midrst_strobe: got %0d required 0", (dv_cnt0 - b) + (fe_cnt0 - fb));
        end
        send_frame(1'b0, 8'h9E, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        checks++;
        if (dv_cnt0 - b !== 1 || rxd0 !== 8'h9E) begin
            errors++;
            $display("FAIL midrst_after: got dv %0d byte %h required 1 9e", dv_cnt0 - b, rxd0);
        end
    endtask

    // Random frames: good bytes must arrive in order, bad stop bits must each give one frame_err.
    task automatic test_random_stream();
        int b, fb, n_good, n_fe, bad_bytes;
        logic [7:0] exp_q [$];
        logic [7:0] d;
        bit bad;
        do_reset();
        b = dv_cnt0; fb = fe_cnt0; n_fe = 0; bad_bytes = 0;
        for (int i = 0; i < 40; i++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            send_frame(1'b0, d, 1'b0, 1'b0, !bad);
            if (bad) begin
                n_fe++;
                idle($urandom_range(0, 2 * CPB));
                line0 = 1'b1;
                idle(CPB);
            end else begin
                exp_q.push_back(d);
                idle($urandom_range(0, CPB));
            end
        end
        idle(2 * CPB);
        n_good = exp_q.size();
        checks++;
        if (dv_cnt0 - b !== n_good || fe_cnt0 - fb !== n_fe) begin
            errors++;
            $display("FAIL rand_counts: got dv %0d fe %0d required %0d %0d",
                     dv_cnt0 - b, fe_cnt0 - fb, n_good, n_fe);
        end
        for (int i = 0; i < n_good; i++)
            if (log0[(b + i) % 256] !== exp_q[i]) bad_bytes++;
        checks++;
        if (bad_bytes !== 0) begin
            errors++;
            $display("FAIL rand_bytes: got %0d wrong bytes required 0", bad_bytes);
        end
    endtask

    // Random parity frames on the even-parity instance.
    task automatic test_random_parity();
        int b, pb, n_pe, bad_bytes;
        logic [7:0] exp_q [$];
        logic [7:0] d;
        bit wrong;
        do_reset();
        b = dv_cnt1; pb = pe_cnt1; n_pe = 0; bad_bytes = 0;
        for (int i = 0; i < 20; i++) begin
            d     = 8'($urandom);
            wrong = ($urandom_range(0, 3) == 0);
            send_frame(1'b1, d, 1'b1, (^d) ^ wrong, 1'b1);
            if (wrong) n_pe++;
            else       exp_q.push_back(d);
            idle($urandom_range(0, CPB));
        end
        idle(2 * CPB);
        checks++;
        if (dv_cnt1 - b !== exp_q.size() || pe_cnt1 - pb !== n_pe) begin
            errors++;
            $display("FAIL randpar_counts: got dv %0d pe %0d required %0d %0d",
                     dv_cnt1 - b, pe_cnt1 - pb, exp_q.size(), n_pe);
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (log1[(b + i) % 256] !== exp_q[i]) bad_bytes++;
        checks++;
        if (bad_bytes !== 0) begin
            errors++;
            $display("FAIL randpar_bytes: got %0d wrong bytes required 0", bad_bytes);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL strobe_exclusive: got %0d overlaps required 0", overlap_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_glitch();
        test_break();
        test_parity();
        test_reset_mid();
        test_random_stream();
        test_random_parity();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
